// File: rtl/piso_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Parallel-in serial-out serializer with valid/ready input and
//            first/last-bit framing strobes; words stream back to back.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] par_data,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int                  c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shifted;
    logic [c_CNT_W-1:0] r_count;
    logic               w_last;
    logic               w_accept;

    assign w_last   = (r_state == c_SHIFT) && (r_count == c_LAST);
    assign w_accept = par_valid && par_ready;

    // The shift register empties itself by zero-fill, so the output bit
    // naturally reads 0 once the last bit has left and the block is idle.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted  = {r_shift[WIDTH-2:0], 1'b0};
            assign serial_out = r_shift[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted  = {1'b0, r_shift[WIDTH-1:1]};
            assign serial_out = r_shift[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (w_last && !w_accept) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state == c_SHIFT);
        serial_valid = (r_state == c_SHIFT);
        frame_start  = (r_state == c_SHIFT) && (r_count == '0);
        frame_done   = w_last;
        par_ready    = (r_state == c_IDLE) || w_last;
    end

    // A word accepted on the last-bit cycle reloads with no idle bit between.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_shift <= par_data;
            r_count <= '0;
        end else if (r_state == c_SHIFT) begin
            r_shift <= w_shifted;
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Brief    : Self-checking bench for piso_serializer (4-bit MSB, 4-bit LSB,
//            8-bit MSB instances); vector table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    logic clk;
    logic rst_n;

    logic       m_valid, m_ready, m_out, m_sv, m_fs, m_fd, m_busy;
    logic [3:0] m_data;
    logic       l_valid, l_ready, l_out, l_sv, l_fs, l_fd, l_busy;
    logic [3:0] l_data;
    logic       w_valid, w_ready, w_out, w_sv, w_fs, w_fd, w_busy;
    logic [7:0] w_data;

    logic [5:0] m_vec;
    assign m_vec = {m_out, m_sv, m_fs, m_fd, m_ready, m_busy};

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb4 (
        .clk(clk), .reset_n(rst_n), .par_data(m_data), .par_valid(m_valid),
        .par_ready(m_ready), .serial_out(m_out), .serial_valid(m_sv),
        .frame_start(m_fs), .frame_done(m_fd), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb4 (
        .clk(clk), .reset_n(rst_n), .par_data(l_data), .par_valid(l_valid),
        .par_ready(l_ready), .serial_out(l_out), .serial_valid(l_sv),
        .frame_start(l_fs), .frame_done(l_fd), .busy(l_busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk(clk), .reset_n(rst_n), .par_data(w_data), .par_valid(w_valid),
        .par_ready(w_ready), .serial_out(w_out), .serial_valid(w_sv),
        .frame_start(w_fs), .frame_done(w_fd), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Row = inputs driven during a cycle and the outputs expected in that
    // cycle, packed as {serial_out, serial_valid, frame_start, frame_done, par_ready, busy}.
    typedef struct {
        logic       v;
        logic [3:0] d;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[20];

    // One 4-bit MSB-first frame on the main instance, starting at a negedge.
    task automatic m_frame(input logic [3:0] word);
        chk("m_ready_before", 8'(m_ready), 8'h01);
        m_valid = 1'b1;
        m_data  = word;
        @(negedge clk);
        m_valid = 1'b0;
        m_data  = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m_frame_bit%0d", i), 8'(m_vec),
                8'({word[3-i], 1'b1, i == 0, i == 3, i == 3, 1'b1}));
            @(negedge clk);
        end
    endtask

    task automatic w_frame(input logic [7:0] word);
        chk("w_ready_before", 8'(w_ready), 8'h01);
        w_valid = 1'b1;
        w_data  = word;
        @(negedge clk);
        w_valid = 1'b0;
        w_data  = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("w_frame_bit%0d", i), 8'({w_out, w_sv, w_fs, w_fd, w_busy}),
                8'({word[7-i], 1'b1, i == 0, i == 7, 1'b1}));
            @(negedge clk);
        end
    endtask

    initial begin
        bit         q[$];
        logic [3:0] word;
        logic       v;
        logic       exp_v;

        tbl[0]  = '{1'b1, 4'hB, 6'b000010};
        tbl[1]  = '{1'b0, 4'h0, 6'b111001};
        tbl[2]  = '{1'b0, 4'h0, 6'b010001};
        tbl[3]  = '{1'b0, 4'h0, 6'b110001};
        tbl[4]  = '{1'b0, 4'h0, 6'b110111};
        tbl[5]  = '{1'b1, 4'hA, 6'b000010};
        tbl[6]  = '{1'b1, 4'h5, 6'b111001};
        tbl[7]  = '{1'b1, 4'h5, 6'b010001};
        tbl[8]  = '{1'b1, 4'h5, 6'b110001};
        tbl[9]  = '{1'b1, 4'h5, 6'b010111};
        tbl[10] = '{1'b0, 4'h0, 6'b011001};
        tbl[11] = '{1'b0, 4'h0, 6'b110001};
        tbl[12] = '{1'b0, 4'h0, 6'b010001};
        tbl[13] = '{1'b0, 4'h0, 6'b110111};
        tbl[14] = '{1'b1, 4'hC, 6'b000010};
        tbl[15] = '{1'b1, 4'h3, 6'b111001};
        tbl[16] = '{1'b1, 4'h3, 6'b110001};
        tbl[17] = '{1'b1, 4'h3, 6'b010001};
        tbl[18] = '{1'b0, 4'h3, 6'b010111};
        tbl[19] = '{1'b0, 4'h0, 6'b000010};

        rst_n   = 1'b0;
        m_valid = 1'b0; m_data = '0;
        l_valid = 1'b0; l_data = '0;
        w_valid = 1'b0; w_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 8'({m_out, m_sv, m_fs, m_fd, m_busy}), 8'h00);
        rst_n = 1'b1;

        // Single word, back-to-back words, valid while busy.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("tbl[%0d]", i), 8'(m_vec), 8'(tbl[i].exp));
            m_valid = tbl[i].v;
            m_data  = tbl[i].d;
        end

        // Reset mid-frame.
        @(negedge clk);
        chk("rst_ready", 8'(m_ready), 8'h01);
        m_valid = 1'b1;
        m_data  = 4'hF;
        @(negedge clk);
        m_valid = 1'b0;
        chk("rst_first_bit", 8'(m_vec), 8'b111001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_clear", 8'({m_out, m_sv, m_fs, m_fd, m_busy}), 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release", 8'({m_ready, m_busy}), 8'b10);
        @(negedge clk);
        chk("rst_no_resume", 8'(m_vec), 8'b000010);
        m_frame(4'h1);
        chk("rst_after_idle", 8'(m_vec), 8'b000010);

        // LSB first.
        l_valid = 1'b1;
        l_data  = 4'b1011;
        word    = 4'b1011;
        @(negedge clk);
        l_valid = 1'b0;
        l_data  = 4'h4;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lsb_bit%0d", i), 8'({l_out, l_sv, l_fs, l_fd, l_ready, l_busy}),
                8'({word[i], 1'b1, i == 0, i == 3, i == 3, 1'b1}));
            @(negedge clk);
        end
        chk("lsb_idle", 8'({l_out, l_sv, l_ready, l_busy}), 8'b0010);

        // Wider word with an idle gap.
        w_frame(8'h96);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("w_gap%0d", g), 8'({w_out, w_sv, w_busy, w_ready}), 8'b0001);
            @(negedge clk);
        end
        w_frame(8'h01);
        chk("w_final_idle", 8'({w_out, w_sv, w_busy}), 8'h00);

        // Random traffic against a bit-queue model: q holds the bits still to
        // appear, the head being the one on serial_out this cycle.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            exp_v = (q.size() != 0);
            chk($sformatf("rand_c%0d", c), 8'(m_vec),
                8'({exp_v ? q[0] : 1'b0, exp_v, q.size() == 4, q.size() == 1,
                    q.size() <= 1, exp_v}));
            v       = ($urandom_range(0, 2) != 0);
            word    = 4'($urandom);
            m_valid = v;
            m_data  = word;
            if (q.size() != 0) void'(q.pop_front());
            if (v && (q.size() == 0)) begin
                for (int b = 3; b >= 0; b--) q.push_back(word[b]);
            end
        end
        m_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
